// File: rtl/tile_reset_sequencer.sv
// Tile reset sequencer: power-on wake-up delay, staggered per-domain reset release,
// and soft-reset handling with a bounded drain wait.
module tile_reset_sequencer #(
    parameter int NumDomains     = 3,
    parameter int WakeUpCycles   = 32768,
    parameter int StaggerCycles  = 4,
    parameter int HoldCycles     = 16,
    parameter int QuiesceTimeout = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  soft_rst_req_i,
    input  logic                  idle_i,
    output logic [NumDomains-1:0] domain_rstn_o,
    output logic                  grst_l_o,
    output logic                  soft_rst_ack_o,
    output logic                  timeout_o
);

    localparam int MaxWs  = (WakeUpCycles > StaggerCycles) ? WakeUpCycles : StaggerCycles;
    localparam int MaxHq  = (HoldCycles > QuiesceTimeout) ? HoldCycles : QuiesceTimeout;
    localparam int MaxAll = (MaxWs > MaxHq) ? MaxWs : MaxHq;
    localparam int CntW   = (MaxAll > 1) ? $clog2(MaxAll) : 1;
    localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [CntW-1:0]       WakeLast    = CntW'(WakeUpCycles - 1);
    localparam logic [CntW-1:0]       StaggerLast = CntW'(StaggerCycles - 1);
    localparam logic [CntW-1:0]       HoldLast    = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0]       QuiesceLast = CntW'(QuiesceTimeout - 1);
    localparam logic [IdxW-1:0]       IdxLast     = IdxW'(NumDomains - 1);
    localparam logic [NumDomains-1:0] DomFirst    = NumDomains'(1);

    typedef enum logic [2:0] {
        ST_WAKEUP  = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_ASSERT  = 3'd4
    } state_t;

    // A single domain has nothing to stagger, so releasing it lands straight in RUN.
    localparam state_t StFirst = (NumDomains == 1) ? ST_RUN : ST_RELEASE;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CntW-1:0]         r_cnt;
    logic [CntW-1:0]         w_cnt_nxt;
    logic [IdxW-1:0]         r_idx;
    logic [IdxW-1:0]         w_idx_nxt;
    logic [IdxW-1:0]         w_idx_inc;
    logic [NumDomains-1:0]   r_dom;
    logic [NumDomains-1:0]   w_dom_nxt;
    logic                    r_grst;
    logic                    r_ack;
    logic                    w_ack_nxt;
    logic                    r_to;
    logic                    w_to_nxt;
    logic                    r_soft;
    logic                    w_soft_nxt;

    assign w_idx_inc = r_idx + IdxW'(1);

    // Next-state, counter, domain-index and output-next logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom;
        w_ack_nxt   = 1'b0;
        w_to_nxt    = r_to;
        w_soft_nxt  = r_soft;
        case (r_state)
            ST_WAKEUP: begin
                // The wake-up count starts only once the global reset copy is out of reset.
                if (r_grst) begin
                    if (r_cnt == WakeLast) begin
                        w_state_nxt = StFirst;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_dom_nxt   = DomFirst;
                        if (NumDomains == 1) begin
                            w_ack_nxt  = r_soft;
                            w_soft_nxt = 1'b0;
                        end else begin
                            w_soft_nxt = r_soft;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == StaggerLast) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = w_idx_inc;
                    w_dom_nxt = r_dom | (DomFirst << w_idx_inc);
                    if (w_idx_inc == IdxLast) begin
                        w_state_nxt = ST_RUN;
                        w_ack_nxt   = r_soft;
                        w_soft_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            ST_RUN: begin
                if (soft_rst_req_i) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                    w_soft_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Idle takes priority over a timeout landing on the same edge.
                if (idle_i) begin
                    w_state_nxt = ST_ASSERT;
                    w_cnt_nxt   = '0;
                    w_dom_nxt   = '0;
                end else if (r_cnt == QuiesceLast) begin
                    w_state_nxt = ST_ASSERT;
                    w_cnt_nxt   = '0;
                    w_dom_nxt   = '0;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            ST_ASSERT: begin
                if (r_cnt == HoldLast) begin
                    w_state_nxt = StFirst;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_dom_nxt   = DomFirst;
                    if (NumDomains == 1) begin
                        w_ack_nxt  = r_soft;
                        w_soft_nxt = 1'b0;
                    end else begin
                        w_soft_nxt = r_soft;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_WAKEUP;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_dom_nxt   = '0;
                w_soft_nxt  = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; everything clears while rst_ni is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_WAKEUP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dom   <= '0;
            r_grst  <= 1'b0;
            r_ack   <= 1'b0;
            r_to    <= 1'b0;
            r_soft  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dom   <= w_dom_nxt;
            r_grst  <= 1'b1;
            r_ack   <= w_ack_nxt;
            r_to    <= w_to_nxt;
            r_soft  <= w_soft_nxt;
        end
    end

    assign domain_rstn_o  = r_dom;
    assign grst_l_o       = r_grst;
    assign soft_rst_ack_o = r_ack;
    assign timeout_o      = r_to;

endmodule

// File: tb/tb_tile_reset_sequencer.sv
// Scoreboard bench for tile_reset_sequencer: expected output events are queued by the
// stimulus process and matched by a monitor whenever any DUT output changes.
module tb_tile_reset_sequencer;

    localparam int N = 3;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         soft_rst_req_i = 1'b0;
    logic         idle_i = 1'b1;
    logic [N-1:0] domain_rstn_o;
    logic         grst_l_o;
    logic         soft_rst_ack_o;
    logic         timeout_o;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = -1;

    typedef struct {
        int           e;
        logic         grst;
        logic [N-1:0] dom;
        logic         ack;
        logic         to;
    } ev_t;

    ev_t exp_q[$];

    tile_reset_sequencer #(
        .NumDomains    (3),
        .WakeUpCycles  (16),
        .StaggerCycles (4),
        .HoldCycles    (8),
        .QuiesceTimeout(32)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .soft_rst_req_i(soft_rst_req_i),
        .idle_i        (idle_i),
        .domain_rstn_o (domain_rstn_o),
        .grst_l_o      (grst_l_o),
        .soft_rst_ack_o(soft_rst_ack_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge 0 is the first rising edge after rst_ni deasserts.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) edge_cnt <= -1;
        else         edge_cnt <= edge_cnt + 1;
    end

    task automatic push(input int e, input logic [N-1:0] dom, input logic ack, input logic to);
        ev_t ev;
        ev.e = e; ev.grst = 1'b1; ev.dom = dom; ev.ack = ack; ev.to = to;
        exp_q.push_back(ev);
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk_i);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({grst_l_o, domain_rstn_o, soft_rst_ack_o, timeout_o} !== '0) begin
            failures++;
            $display("FAIL %s got grst=%b dom=%b ack=%b to=%b expected all 0",
                     name, grst_l_o, domain_rstn_o, soft_rst_ack_o, timeout_o);
        end
    endtask

    // Monitor: every output change outside reset must match the next queued event.
    initial begin
        logic [N+2:0] prev;
        logic [N+2:0] cur;
        ev_t          ev;
        prev = '0;
        forever begin
            @(negedge clk_i);
            cur = {grst_l_o, domain_rstn_o, soft_rst_ack_o, timeout_o};
            if (!rst_ni) begin
                prev = '0;
            end else if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event edge=%0d got grst=%b dom=%b ack=%b to=%b",
                             edge_cnt, grst_l_o, domain_rstn_o, soft_rst_ack_o, timeout_o);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.e != edge_cnt || cur !== {ev.grst, ev.dom, ev.ack, ev.to}) begin
                        failures++;
                        $display("FAIL event edge=%0d got grst=%b dom=%b ack=%b to=%b expected edge=%0d grst=%b dom=%b ack=%b to=%b",
                                 edge_cnt, grst_l_o, domain_rstn_o, soft_rst_ack_o, timeout_o,
                                 ev.e, ev.grst, ev.dom, ev.ack, ev.to);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #3 check_zero("reset_state");
        @(negedge clk_i);
        @(negedge clk_i);

        // Power-on: grst at edge 0, domains at 16/20/24, no ack.
        push(0,  3'b000, 1'b0, 1'b0);
        push(16, 3'b001, 1'b0, 1'b0);
        push(20, 3'b011, 1'b0, 1'b0);
        push(24, 3'b111, 1'b0, 1'b0);
        rst_ni = 1'b1;

        // Soft reset with idle high, T=30.
        push(31, 3'b000, 1'b0, 1'b0);
        push(39, 3'b001, 1'b0, 1'b0);
        push(43, 3'b011, 1'b0, 1'b0);
        push(47, 3'b111, 1'b1, 1'b0);
        push(48, 3'b111, 1'b0, 1'b0);
        wait_edge(29); soft_rst_req_i = 1'b1;
        wait_edge(30); soft_rst_req_i = 1'b0;

        // Idle arrives exactly on the timeout edge, T=70: idle wins, no timeout.
        push(102, 3'b000, 1'b0, 1'b0);
        push(110, 3'b001, 1'b0, 1'b0);
        push(114, 3'b011, 1'b0, 1'b0);
        push(118, 3'b111, 1'b1, 1'b0);
        push(119, 3'b111, 1'b0, 1'b0);
        wait_edge(69); soft_rst_req_i = 1'b1; idle_i = 1'b0;
        wait_edge(70); soft_rst_req_i = 1'b0;
        wait_edge(101); idle_i = 1'b1;
        wait_edge(102); idle_i = 1'b0;

        // Drain timeout with idle low, T=130; timeout stays set after ack.
        push(162, 3'b000, 1'b0, 1'b1);
        push(170, 3'b001, 1'b0, 1'b1);
        push(174, 3'b011, 1'b0, 1'b1);
        push(178, 3'b111, 1'b1, 1'b1);
        push(179, 3'b111, 1'b0, 1'b1);
        wait_edge(129); soft_rst_req_i = 1'b1;
        wait_edge(130); soft_rst_req_i = 1'b0;
        wait_edge(185);

        #2 rst_ni = 1'b0;
        #1 check_zero("async_reset_in_run");
        @(negedge clk_i);
        @(negedge clk_i);

        // Wake-up aborted by reset right after domain 1 is released.
        push(0,  3'b000, 1'b0, 1'b0);
        push(16, 3'b001, 1'b0, 1'b0);
        push(20, 3'b011, 1'b0, 1'b0);
        idle_i = 1'b1;
        rst_ni = 1'b1;
        wait_edge(22);
        #2 rst_ni = 1'b0;
        #1 check_zero("async_reset_mid_stagger");
        @(negedge clk_i);
        @(negedge clk_i);

        // Full rerun with a request pulse during wake-up that must be ignored.
        push(0,  3'b000, 1'b0, 1'b0);
        push(16, 3'b001, 1'b0, 1'b0);
        push(20, 3'b011, 1'b0, 1'b0);
        push(24, 3'b111, 1'b0, 1'b0);
        rst_ni = 1'b1;
        wait_edge(1);  soft_rst_req_i = 1'b1;
        wait_edge(10); soft_rst_req_i = 1'b0;
        wait_edge(40);

        while (exp_q.size() > 0) begin
            ev_t ev;
            ev = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event expected edge=%0d dom=%b ack=%b to=%b got no output change",
                     ev.e, ev.dom, ev.ack, ev.to);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
